// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Purpose  : Bundles the ICACHE and MEM requester ports and the RAM
//            controller port of ram_arbiter.
// Ports    : ICACHE : re / addr in, data / status out
//            MEM    : re / we / addr / wdata in, data / status out
//            RAM    : req / we / addr / wdata out, rdata / ack in
// Modports : slave  - the arbiter's view
//            master - the surrounding requesters and RAM controller
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int ADDR_W = 17
);
  // ICACHE requester
  logic              re_ICACHE_i;
  logic [31:0]       addr_ICACHE_i;
  logic [7:0]        data_ICACHE_o;
  logic              status_ICACHE_o;
  // MEM requester
  logic              re_MEM_i;
  logic              we_MEM_i;
  logic [31:0]       addr_MEM_i;
  logic [7:0]        wdata_MEM_i;
  logic [7:0]        data_MEM_o;
  logic              status_MEM_o;
  // RAM controller
  logic              ram_req_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i;
  logic              ram_ack_i;

  modport slave (
    input  re_ICACHE_i, addr_ICACHE_i,
    output data_ICACHE_o, status_ICACHE_o,
    input  re_MEM_i, we_MEM_i, addr_MEM_i, wdata_MEM_i,
    output data_MEM_o, status_MEM_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i, ram_ack_i
  );

  modport master (
    output re_ICACHE_i, addr_ICACHE_i,
    input  data_ICACHE_o, status_ICACHE_o,
    output re_MEM_i, we_MEM_i, addr_MEM_i, wdata_MEM_i,
    input  data_MEM_o, status_MEM_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i, ram_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one byte-wide RAM controller port between the ICACHE
//            line-fill engine and the MEM stage. One byte per transaction,
//            non-preemptive. MEM has priority, but ICACHE wins after
//            MEM_BURST_MAX consecutive MEM grants while it was waiting.
// Ports    : clk  - clock
//            rst  - asynchronous active-low reset
//            bus  - ram_arbiter_if.slave (requester and RAM ports)
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W        = 17,
  parameter int MEM_BURST_MAX = 4
) (
  input  wire           clk,
  input  wire           rst,
  ram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_BURST_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Registered state
  state_t            state_q,        state_d;
  logic              owner_mem_q,    owner_mem_d;
  logic              ram_req_q,      ram_req_d;
  logic              ram_we_q,       ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,     ram_addr_d;
  logic [7:0]        ram_wdata_q,    ram_wdata_d;
  logic [7:0]        data_ic_q,      data_ic_d;
  logic [7:0]        data_mem_q,     data_mem_d;
  logic              ic_srv_v_q,     ic_srv_v_d;
  logic [ADDR_W-1:0] ic_srv_addr_q,  ic_srv_addr_d;
  logic              mem_srv_v_q,    mem_srv_v_d;
  logic [ADDR_W-1:0] mem_srv_addr_q, mem_srv_addr_d;
  logic              mem_srv_we_q,   mem_srv_we_d;
  logic [CNT_W-1:0]  mem_cnt_q,      mem_cnt_d;

  // Requester decode
  logic [ADDR_W-1:0] ic_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              ic_pend;
  logic              mem_pend;
  logic              ic_first;
  logic              grant_ic;
  logic              grant_mem;

  // Address bits above the RAM width are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.addr_ICACHE_i[31:ADDR_W], bus.addr_MEM_i[31:ADDR_W]};

  assign ic_addr  = bus.addr_ICACHE_i[ADDR_W-1:0];
  assign mem_addr = bus.addr_MEM_i[ADDR_W-1:0];
  // A simultaneous read+write is treated as a write, so we_MEM_i alone is the op.
  assign mem_en   = bus.re_MEM_i | bus.we_MEM_i;

  // A request is pending until the served record matches it exactly.
  assign ic_pend  = bus.re_ICACHE_i &
                    ~(ic_srv_v_q && (ic_srv_addr_q == ic_addr));
  assign mem_pend = mem_en &
                    ~(mem_srv_v_q && (mem_srv_addr_q == mem_addr) &&
                      (mem_srv_we_q == bus.we_MEM_i));

  // ICACHE goes first when MEM is idle or MEM has used its burst allowance.
  assign ic_first  = ic_pend && (!mem_pend || (mem_cnt_q == CNT_MAX));
  assign grant_ic  = (state_q == ST_IDLE) && ic_first;
  assign grant_mem = (state_q == ST_IDLE) && mem_pend && !ic_first;

  always_comb begin
    state_d        = state_q;
    owner_mem_d    = owner_mem_q;
    ram_req_d      = ram_req_q;
    ram_we_d       = ram_we_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    data_ic_d      = data_ic_q;
    data_mem_d     = data_mem_q;
    ic_srv_v_d     = ic_srv_v_q;
    ic_srv_addr_d  = ic_srv_addr_q;
    mem_srv_v_d    = mem_srv_v_q;
    mem_srv_addr_d = mem_srv_addr_q;
    mem_srv_we_d   = mem_srv_we_q;
    mem_cnt_d      = mem_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_ic) begin
          owner_mem_d = 1'b0;
          ram_addr_d  = ic_addr;
          ram_we_d    = 1'b0;
          ram_wdata_d = 8'h00;
          ram_req_d   = 1'b1;
          state_d     = ST_REQ;
        end else if (grant_mem) begin
          owner_mem_d = 1'b1;
          ram_addr_d  = mem_addr;
          ram_we_d    = bus.we_MEM_i;
          ram_wdata_d = bus.wdata_MEM_i;
          ram_req_d   = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // The record takes the registered address/op, not the live inputs,
        // so a requester that moved on mid-transfer stays BUSY.
        if (bus.ram_ack_i) begin
          ram_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (owner_mem_q) begin
            mem_srv_v_d    = 1'b1;
            mem_srv_addr_d = ram_addr_q;
            mem_srv_we_d   = ram_we_q;
            if (!ram_we_q) data_mem_d = bus.ram_rdata_i;
          end else begin
            ic_srv_v_d    = 1'b1;
            ic_srv_addr_d = ram_addr_q;
            data_ic_d     = bus.ram_rdata_i;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ram_req_d = 1'b0;
      end
    endcase

    // Dropping all enables forgets the record, which allows a repeat access.
    if (!bus.re_ICACHE_i) ic_srv_v_d  = 1'b0;
    if (!mem_en)          mem_srv_v_d = 1'b0;

    // Consecutive-MEM-grant counter, only meaningful while ICACHE waits.
    if (!ic_pend || grant_ic) mem_cnt_d = '0;
    else if (grant_mem)       mem_cnt_d = mem_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      owner_mem_q    <= 1'b0;
      ram_req_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= 8'h00;
      data_ic_q      <= 8'h00;
      data_mem_q     <= 8'h00;
      ic_srv_v_q     <= 1'b0;
      ic_srv_addr_q  <= '0;
      mem_srv_v_q    <= 1'b0;
      mem_srv_addr_q <= '0;
      mem_srv_we_q   <= 1'b0;
      mem_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_mem_q    <= owner_mem_d;
      ram_req_q      <= ram_req_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      data_ic_q      <= data_ic_d;
      data_mem_q     <= data_mem_d;
      ic_srv_v_q     <= ic_srv_v_d;
      ic_srv_addr_q  <= ic_srv_addr_d;
      mem_srv_v_q    <= mem_srv_v_d;
      mem_srv_addr_q <= mem_srv_addr_d;
      mem_srv_we_q   <= mem_srv_we_d;
      mem_cnt_q      <= mem_cnt_d;
    end
  end

  assign bus.ram_req_o       = ram_req_q;
  assign bus.ram_we_o        = ram_we_q;
  assign bus.ram_addr_o      = ram_addr_q;
  assign bus.ram_wdata_o     = ram_wdata_q;
  assign bus.data_ICACHE_o   = data_ic_q;
  assign bus.data_MEM_o      = data_mem_q;
  assign bus.status_ICACHE_o = ic_pend;
  assign bus.status_MEM_o    = mem_pend;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Directed self-checking bench for ram_arbiter. A small RAM
//            responder acks after a programmable delay and returns
//            rdata = addr[7:0] + 0x95.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  localparam int ADDR_W = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  ram_arbiter #(.ADDR_W(ADDR_W), .MEM_BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
    return a[7:0] + 8'h95;
  endfunction

  // RAM responder
  int                ack_dly   = 0;
  bit                auto_ack  = 1'b1;
  bit                man_ack   = 1'b0;
  logic [7:0]        man_rdata = 8'h00;
  int                wait_cnt  = 0;
  logic [ADDR_W-1:0] wr_addr_log = '0;
  logic [7:0]        wr_data_log = 8'h00;

  initial begin
    bus.ram_ack_i   = 1'b0;
    bus.ram_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      if (!auto_ack) begin
        bus.ram_ack_i   = man_ack;
        bus.ram_rdata_i = man_rdata;
        wait_cnt        = 0;
      end else if (bus.ram_req_o) begin
        if (wait_cnt == ack_dly) begin
          bus.ram_ack_i   = 1'b1;
          bus.ram_rdata_i = rom(bus.ram_addr_o);
          if (bus.ram_we_o) begin
            wr_addr_log = bus.ram_addr_o;
            wr_data_log = bus.ram_wdata_o;
          end
          wait_cnt = 0;
        end else begin
          bus.ram_ack_i   = 1'b0;
          bus.ram_rdata_i = 8'h00;
          wait_cnt++;
        end
      end else begin
        bus.ram_ack_i = 1'b0;
        wait_cnt      = 0;
      end
    end
  end

  // Grant monitor: logs the address of every new RAM request
  logic [ADDR_W-1:0] grant_log[$];
  logic              prev_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ram_req_o && !prev_req) grant_log.push_back(bus.ram_addr_o);
      prev_req = bus.ram_req_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] exp_log[9];
  int  idx;
  bit  done;

  initial begin
    bus.re_ICACHE_i   = 1'b1;
    bus.addr_ICACHE_i = 32'h10;
    bus.re_MEM_i      = 1'b0;
    bus.we_MEM_i      = 1'b0;
    bus.addr_MEM_i    = 32'h0;
    bus.wdata_MEM_i   = 8'h00;

    // ---- Reset state with ICACHE enabled
    repeat (2) @(negedge clk);
    check("rst_req",      bus.ram_req_o,       0);
    check("rst_we",       bus.ram_we_o,        0);
    check("rst_addr",     bus.ram_addr_o,      0);
    check("rst_wdata",    bus.ram_wdata_o,     0);
    check("rst_data_ic",  bus.data_ICACHE_o,   0);
    check("rst_data_mem", bus.data_MEM_o,      0);
    check("rst_stat_ic",  bus.status_ICACHE_o, 1);
    check("rst_stat_mem", bus.status_MEM_o,    0);

    // ---- ICACHE single read, ack in first req cycle
    rst = 1'b1;                         // cycle 0
    @(negedge clk);                     // cycle 1
    check("ic1_req",     bus.ram_req_o,       1);
    check("ic1_addr",    bus.ram_addr_o,      32'h10);
    check("ic1_we",      bus.ram_we_o,        0);
    check("ic1_stat_c1", bus.status_ICACHE_o, 1);
    @(negedge clk);                     // cycle 2
    check("ic1_data",    bus.data_ICACHE_o,   8'hA5);
    check("ic1_stat_c2", bus.status_ICACHE_o, 0);
    check("ic1_req_c2",  bus.ram_req_o,       0);
    bus.re_ICACHE_i = 1'b0;
    @(negedge clk);

    // ---- MEM write, ack delayed 3 cycles
    ack_dly         = 3;
    bus.we_MEM_i    = 1'b1;
    bus.addr_MEM_i  = 32'h20;
    bus.wdata_MEM_i = 8'h3C;
    #1 check("wr_stat_c0", bus.status_MEM_o, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("wr_req_c%0d",   c), bus.ram_req_o,    1);
      check($sformatf("wr_we_c%0d",    c), bus.ram_we_o,     1);
      check($sformatf("wr_wdata_c%0d", c), bus.ram_wdata_o,  8'h3C);
      check($sformatf("wr_stat_c%0d",  c), bus.status_MEM_o, 1);
    end
    @(negedge clk);                     // cycle 5
    check("wr_stat_done", bus.status_MEM_o, 0);
    check("wr_req_done",  bus.ram_req_o,    0);
    check("wr_data_mem",  bus.data_MEM_o,   0);
    check("wr_ram_addr",  wr_addr_log,      32'h20);
    check("wr_ram_data",  wr_data_log,      8'h3C);
    @(negedge clk);                     // held enable: no repeat write
    check("wr_norepeat_stat", bus.status_MEM_o, 0);
    check("wr_norepeat_req",  bus.ram_req_o,    0);
    bus.we_MEM_i = 1'b0;
    @(negedge clk);

    // ---- Simultaneous ICACHE 0x40 and MEM 0x80, ack delay 1
    ack_dly           = 1;
    bus.re_ICACHE_i   = 1'b1;
    bus.addr_ICACHE_i = 32'h40;
    bus.re_MEM_i      = 1'b1;
    bus.addr_MEM_i    = 32'h80;
    @(negedge clk);                     // cycle 1
    check("sim_first_addr", bus.ram_addr_o, 32'h80);
    check("sim_first_req",  bus.ram_req_o,  1);
    @(negedge clk);                     // cycle 2: ack
    @(negedge clk);                     // cycle 3
    check("sim_mem_stat",  bus.status_MEM_o,    0);
    check("sim_mem_data",  bus.data_MEM_o,      8'h15);
    check("sim_ic_stat3",  bus.status_ICACHE_o, 1);
    check("sim_idle_req",  bus.ram_req_o,       0);
    @(negedge clk);                     // cycle 4
    check("sim_second_req",  bus.ram_req_o,  1);
    check("sim_second_addr", bus.ram_addr_o, 32'h40);
    @(negedge clk);                     // cycle 5: ack
    check("sim_ic_stat5", bus.status_ICACHE_o, 1);
    @(negedge clk);                     // cycle 6
    check("sim_ic_stat6",  bus.status_ICACHE_o, 0);
    check("sim_ic_data",   bus.data_ICACHE_o,   8'hD5);
    check("sim_mem_hold",  bus.data_MEM_o,      8'h15);
    bus.re_ICACHE_i = 1'b0;
    bus.re_MEM_i    = 1'b0;
    @(negedge clk);

    // ---- Starvation: MEM streams 0x100..0x107 while ICACHE waits
    ack_dly = 0;
    grant_log.delete();
    bus.re_ICACHE_i   = 1'b1;
    bus.addr_ICACHE_i = 32'h200;
    bus.re_MEM_i      = 1'b1;
    bus.addr_MEM_i    = 32'h100;
    idx  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.status_MEM_o) begin
        if (idx == 7) done = 1'b1;
        else begin
          idx++;
          bus.addr_MEM_i = 32'h100 + idx;
        end
      end
    end
    bus.re_MEM_i = 1'b0;
    check("starve_done", done, 1);
    exp_log = '{17'h100, 17'h101, 17'h102, 17'h103, 17'h200,
                17'h104, 17'h105, 17'h106, 17'h107};
    check("starve_count", grant_log.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < grant_log.size())
        check($sformatf("starve_grant%0d", i), grant_log[i], exp_log[i]);
    end
    check("starve_ic_data", bus.data_ICACHE_o,   8'h95);
    check("starve_ic_stat", bus.status_ICACHE_o, 0);
    bus.re_ICACHE_i = 1'b0;
    @(negedge clk);

    // ---- Reset mid-REQ
    bus.re_MEM_i   = 1'b1;
    bus.addr_MEM_i = 32'h50;
    repeat (3) @(negedge clk);
    check("rr_mem_served", bus.status_MEM_o, 0);
    check("rr_mem_data",   bus.data_MEM_o,   8'hE5);
    ack_dly           = 10;
    bus.re_ICACHE_i   = 1'b1;
    bus.addr_ICACHE_i = 32'h300;
    @(negedge clk);                     // cycle 1
    check("rr_req_up",  bus.ram_req_o,  1);
    check("rr_addr",    bus.ram_addr_o, 32'h300);
    #2 rst = 1'b0;
    #1;
    check("rr_req_async",  bus.ram_req_o,       0);
    check("rr_stat_ic",    bus.status_ICACHE_o, 1);
    check("rr_stat_mem",   bus.status_MEM_o,    1);
    check("rr_data_ic",    bus.data_ICACHE_o,   0);
    check("rr_data_mem",   bus.data_MEM_o,      0);
    auto_ack  = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 8'hEE;
    @(negedge clk);                     // late ack lands in IDLE
    rst             = 1'b1;
    bus.re_ICACHE_i = 1'b0;
    bus.re_MEM_i    = 1'b0;
    man_ack         = 1'b0;
    @(negedge clk);
    check("rr_late_data_ic",  bus.data_ICACHE_o, 0);
    check("rr_late_data_mem", bus.data_MEM_o,    0);
    check("rr_late_req",      bus.ram_req_o,     0);
    auto_ack       = 1'b1;
    ack_dly        = 0;
    bus.re_MEM_i   = 1'b1;
    bus.addr_MEM_i = 32'h50;
    #1 check("rr_mem_rebusy", bus.status_MEM_o, 1);
    repeat (3) @(negedge clk);
    check("rr_mem_reserved", bus.status_MEM_o, 0);
    check("rr_mem_redata",   bus.data_MEM_o,   8'hE5);
    bus.re_MEM_i = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
